// File: rtl/regfile_arb_pkg.sv
// Shared types and defaults for the two-requester register-file access arbiter.
// The FSM encoding, requester IDs and width defaults live here.
package regfile_arb_pkg;

  localparam int WORD_LENGTH_DEF = 32;
  localparam int NBITS_DEF       = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_A = 1'b0;
  localparam req_id_t REQ_B = 1'b1;

endpackage

// File: rtl/regfile_access_arbiter_rr_picker2.sv
// Two-way round-robin choice: on contention the requester not granted last wins.
module rr_picker2
  import regfile_arb_pkg::*;
(
  input  logic    req_a,
  input  logic    req_b,
  input  req_id_t last_grant,
  output req_id_t winner
);

  always_comb begin
    if (req_a && req_b) begin
      winner = (last_grant == REQ_A) ? REQ_B : REQ_A;
    end else if (req_b) begin
      winner = REQ_B;
    end else begin
      winner = REQ_A;
    end
  end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Serializes register-file reads and writes from two requesters (A/B) through
// a single 32:1 read mux and one write port, with round-robin arbitration.
module regfile_access_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int WORD_LENGTH = WORD_LENGTH_DEF,
  parameter int NBITS       = NBITS_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Req_A,
  input  logic                   Req_B,
  input  logic                   Write_A,
  input  logic                   Write_B,
  input  logic [NBITS-1:0]       Addr_A,
  input  logic [NBITS-1:0]       Addr_B,
  input  logic [WORD_LENGTH-1:0] WrData_A,
  input  logic [WORD_LENGTH-1:0] WrData_B,
  output logic                   Grant_A,
  output logic                   Grant_B,
  output logic                   RdValid_A,
  output logic                   RdValid_B,
  output logic [WORD_LENGTH-1:0] RdData,
  output logic [NBITS-1:0]       Selector,
  input  logic [WORD_LENGTH-1:0] Mux_Output,
  output logic                   Write_Enable,
  output logic [NBITS-1:0]       Write_Addr,
  output logic [WORD_LENGTH-1:0] Write_Data,
  output logic                   Busy
);

  state_t                 state_reg, state_next;
  req_id_t                prio_reg;
  req_id_t                id_reg;
  logic                   write_reg;
  logic [NBITS-1:0]       addr_reg;
  logic [WORD_LENGTH-1:0] data_reg;
  logic [WORD_LENGTH-1:0] rd_data_reg;
  req_id_t                winner;
  logic                   any_req;

  assign any_req = Req_A | Req_B;

  // prio_reg names the requester favoured on contention, so the picker's
  // "last granted" is simply the other one.
  rr_picker2 u_picker (
    .req_a      (Req_A),
    .req_b      (Req_B),
    .last_grant (req_id_t'(~prio_reg)),
    .winner     (winner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      prio_reg    <= REQ_A;
      id_reg      <= REQ_A;
      write_reg   <= 1'b0;
      addr_reg    <= '0;
      data_reg    <= '0;
      rd_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && any_req) begin
        id_reg    <= winner;
        write_reg <= (winner == REQ_B) ? Write_B : Write_A;
        addr_reg  <= (winner == REQ_B) ? Addr_B : Addr_A;
        data_reg  <= (winner == REQ_B) ? WrData_B : WrData_A;
        prio_reg  <= req_id_t'(~winner);
      end
      if (state_reg == ACCESS && !write_reg) begin
        rd_data_reg <= Mux_Output;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    Grant_A      = 1'b0;
    Grant_B      = 1'b0;
    RdValid_A    = 1'b0;
    RdValid_B    = 1'b0;
    Selector     = '0;
    Write_Enable = 1'b0;
    Write_Addr   = '0;
    Write_Data   = '0;
    Busy         = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (any_req) state_next = ACCESS;
      end
      ACCESS: begin
        Grant_A  = (id_reg == REQ_A);
        Grant_B  = (id_reg == REQ_B);
        Selector = addr_reg;
        // Register 0 is read-only: the grant still pulses but the write is dropped.
        if (write_reg && addr_reg != '0) begin
          Write_Enable = 1'b1;
          Write_Addr   = addr_reg;
          Write_Data   = data_reg;
        end
        state_next = write_reg ? IDLE : RESP;
      end
      RESP: begin
        RdValid_A  = (id_reg == REQ_A);
        RdValid_B  = (id_reg == REQ_B);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign RdData = rd_data_reg;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Scoreboard bench: drivers issue A/B transactions, a transaction-level model
// predicts grant order and read data, a negedge monitor checks DUT outputs.
module tb_regfile_access_arbiter;

  localparam int WL = 32;
  localparam int NB = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          Req_A = 1'b0, Req_B = 1'b0;
  logic          Write_A = 1'b0, Write_B = 1'b0;
  logic [NB-1:0] Addr_A = '0, Addr_B = '0;
  logic [WL-1:0] WrData_A = '0, WrData_B = '0;
  logic          Grant_A, Grant_B, RdValid_A, RdValid_B;
  logic [WL-1:0] RdData, Mux_Output, Write_Data;
  logic [NB-1:0] Selector, Write_Addr;
  logic          Write_Enable, Busy;

  regfile_access_arbiter #(.WORD_LENGTH(WL), .NBITS(NB)) dut (
    .clk(clk), .reset(reset),
    .Req_A(Req_A), .Req_B(Req_B), .Write_A(Write_A), .Write_B(Write_B),
    .Addr_A(Addr_A), .Addr_B(Addr_B), .WrData_A(WrData_A), .WrData_B(WrData_B),
    .Grant_A(Grant_A), .Grant_B(Grant_B), .RdValid_A(RdValid_A), .RdValid_B(RdValid_B),
    .RdData(RdData), .Selector(Selector), .Mux_Output(Mux_Output),
    .Write_Enable(Write_Enable), .Write_Addr(Write_Addr), .Write_Data(Write_Data),
    .Busy(Busy)
  );

  always #5 clk = ~clk;

  // Register file environment behind the mux and write port, preloaded with i.
  logic [WL-1:0] rf [32];
  assign Mux_Output = rf[Selector];
  always @(posedge clk) if (Write_Enable) rf[Write_Addr] <= Write_Data;

  typedef struct {
    bit            write;
    logic [NB-1:0] addr;
    logic [WL-1:0] data;
    int            gap;
    int            raise_cyc;
  } txn_t;

  typedef struct {
    bit            id;
    logic [WL-1:0] data;
    int            cyc;
  } rd_t;

  txn_t          stim_a[$], stim_b[$], pend_a[$], pend_b[$];
  rd_t           rd_exp[$];
  logic [WL-1:0] model_mem [32];
  bit            prio_m = 1'b0;
  bit            snap_a = 1'b0, snap_b = 1'b0;
  logic [WL-1:0] last_rd = '0;
  bit            drv_busy [2];
  int            lat [2];
  int            grant_cyc [2];
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_txn(input bit id, input bit wr, input int addr, input logic [WL-1:0] data, input int gap);
    txn_t t;
    t.write = wr; t.addr = addr[NB-1:0]; t.data = data; t.gap = gap; t.raise_cyc = 0;
    if (id) stim_b.push_back(t); else stim_a.push_back(t);
  endtask

  task automatic set_req(input bit id, input bit r, input txn_t t);
    if (id) begin
      Req_B = r; Write_B = t.write; Addr_B = t.addr; WrData_B = t.data;
    end else begin
      Req_A = r; Write_A = t.write; Addr_A = t.addr; WrData_A = t.data;
    end
  endtask

  // Holds Req until the matching Grant, then moves straight to the next item.
  task automatic drive(input bit id);
    txn_t t;
    bit   granted;
    forever begin
      @(posedge clk); #1;
      if ((id ? stim_b.size() : stim_a.size()) == 0) begin
        if (id) Req_B = 1'b0; else Req_A = 1'b0;
        continue;
      end
      drv_busy[id] = 1'b1;
      t = id ? stim_b.pop_front() : stim_a.pop_front();
      if (t.gap > 0) begin
        if (id) Req_B = 1'b0; else Req_A = 1'b0;
        repeat (t.gap) @(posedge clk);
        #1;
      end
      t.raise_cyc = cyc;
      if (id) pend_b.push_back(t); else pend_a.push_back(t);
      set_req(id, 1'b1, t);
      granted = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (id ? Grant_B : Grant_A) begin granted = 1'b1; break; end
      end
      if (!granted) begin
        check(id ? "grant_timeout_b" : "grant_timeout_a", 64'd0, 64'd1);
        if (id) void'(pend_b.pop_front()); else void'(pend_a.pop_front());
      end
      drv_busy[id] = 1'b0;
    end
  endtask

  initial drive(1'b0);
  initial drive(1'b1);

  always @(negedge clk) begin
    bit   gid, rid;
    int   exp_id;
    txn_t t;
    rd_t  r;
    if (!reset) begin
      check("grant_excl", 64'(Grant_A & Grant_B), 64'd0);
      check("rdvalid_excl", 64'(RdValid_A & RdValid_B), 64'd0);
      if (Grant_A || Grant_B) begin
        gid = Grant_B;
        if (snap_a && snap_b) exp_id = int'(prio_m);
        else if (snap_a)      exp_id = 0;
        else if (snap_b)      exp_id = 1;
        else                  exp_id = 2;
        check("grant_winner", 64'(gid), 64'(exp_id));
        prio_m = !gid;
        grant_cyc[gid] = cyc;
        if ((gid ? pend_b.size() : pend_a.size()) == 0) begin
          check("grant_no_request", 64'd1, 64'd0);
        end else begin
          t = gid ? pend_b.pop_front() : pend_a.pop_front();
          lat[gid] = cyc - t.raise_cyc;
          check("selector", 64'(Selector), 64'(t.addr));
          check("busy_access", 64'(Busy), 64'd1);
          if (t.write) begin
            check("wr_enable", 64'(Write_Enable), 64'(t.addr != 0));
            if (t.addr != 0) begin
              check("wr_addr", 64'(Write_Addr), 64'(t.addr));
              check("wr_data", 64'(Write_Data), 64'(t.data));
              model_mem[t.addr] = t.data;
            end
          end else begin
            check("rd_no_write", 64'(Write_Enable), 64'd0);
            rd_exp.push_back('{gid, model_mem[t.addr], cyc});
          end
        end
      end else begin
        check("idle_wr_sel", {Selector, Write_Enable, Write_Addr, Write_Data}, 64'd0);
      end
      if (RdValid_A || RdValid_B) begin
        rid = RdValid_B;
        if (rd_exp.size() == 0) begin
          check("rdvalid_unexpected", 64'd1, 64'd0);
        end else begin
          r = rd_exp.pop_front();
          check("rd_id", 64'(rid), 64'(r.id));
          check("rd_data", 64'(RdData), 64'(r.data));
          check("rd_latency", 64'(cyc - r.cyc), 64'd1);
          last_rd = r.data;
        end
      end else begin
        check("rddata_hold", 64'(RdData), 64'(last_rd));
        if (rd_exp.size() > 0 && cyc > rd_exp[0].cyc + 1) begin
          check("rdvalid_missing", 64'd0, 64'd1);
          void'(rd_exp.pop_front());
        end
      end
    end
    snap_a = Req_A;
    snap_b = Req_B;
  end

  task automatic check_reset_outputs(input string name);
    check(name, {Grant_A, Grant_B, RdValid_A, RdValid_B, Busy, Selector,
                 Write_Enable, Write_Addr, Write_Data}, 64'd0);
    check({name, "_rddata"}, 64'(RdData), 64'd0);
  endtask

  task automatic clear_model();
    rd_exp.delete(); pend_a.delete(); pend_b.delete();
    prio_m = 1'b0; last_rd = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_model();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_outputs");
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (stim_a.size() == 0 && stim_b.size() == 0 && pend_a.size() == 0 &&
          pend_b.size() == 0 && rd_exp.size() == 0 && !drv_busy[0] && !drv_busy[1] &&
          !Req_A && !Req_B && !Busy) begin
        done = 1'b1;
        break;
      end
    end
    check("idle_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 32; i++) begin
      rf[i] = WL'(i);
      model_mem[i] = WL'(i);
    end
    drv_busy[0] = 1'b0; drv_busy[1] = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_outputs");
    reset = 1'b0;

    // single read, uncontended latency
    push_txn(1'b0, 1'b0, 3, '0, 0);
    wait_idle(50);
    check("single_read_grant_lat", 64'(lat[0]), 64'd1);

    // simultaneous reads after reset: A first, B three cycles later
    do_reset();
    push_txn(1'b0, 1'b0, 5, '0, 0);
    push_txn(1'b1, 1'b0, 16, '0, 0);
    wait_idle(50);
    check("contended_read_spacing", 64'(grant_cyc[1] - grant_cyc[0]), 64'd3);

    // A writes 25 while B reads 25
    push_txn(1'b0, 1'b1, 25, 32'hDEADBEEF, 0);
    push_txn(1'b1, 1'b0, 25, '0, 0);
    wait_idle(50);

    // write to address 0 is dropped
    push_txn(1'b0, 1'b1, 0, 32'd7, 0);
    wait_idle(50);
    push_txn(1'b1, 1'b0, 0, '0, 0);
    wait_idle(50);

    // reset asserted during the ACCESS cycle of a read
    push_txn(1'b0, 1'b0, 9, '0, 0);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (Grant_A) begin seen = 1'b1; break; end
    end
    check("mid_reset_grant_seen", 64'(seen), 64'd1);
    #1 reset = 1'b1;
    clear_model();
    #1 check_reset_outputs("mid_reset_outputs");
    repeat (3) @(negedge clk);
    check_reset_outputs("mid_reset_hold");
    reset = 1'b0;
    push_txn(1'b0, 1'b0, 7, '0, 0);
    push_txn(1'b1, 1'b0, 12, '0, 0);
    wait_idle(50);

    // randomized mixed traffic on a small address set to force collisions
    for (int i = 0; i < 120; i++) begin
      push_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 7)), $urandom, int'($urandom_range(0, 3)));
    end
    wait_idle(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_access_arbiter.md
REGFILE_ACCESS_ARBITER -- requirements
Module: regfile_access_arbiter

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 32, data width of each register and of the 32:1 read mux.
REQ-002 SHALL have parameter NBITS, default 5 (CeilLog2 of 32), register address and mux Selector width.
REQ-003 SHALL have one clock and one reset. clk is the single clock. reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 Req_A / Req_B  input  1  access request from requester A / B; held high until granted.
REQ-007 Write_A / Write_B  input  1  1 = write, 0 = read; valid while the matching Req is high.
REQ-008 Addr_A / Addr_B  input  NBITS  register address.
REQ-009 WrData_A / WrData_B  input  WORD_LENGTH  write data.
REQ-010 Grant_A / Grant_B  output  1  one-cycle grant pulse.
REQ-011 RdValid_A / RdValid_B  output  1  one-cycle read-data-valid pulse.
REQ-012 RdData  output  WORD_LENGTH  read data, shared by both requesters.
REQ-013 Selector  output  NBITS  drives the 32:1 mux select.
REQ-014 Mux_Output  input  WORD_LENGTH  the 32:1 mux output.
REQ-015 Write_Enable / Write_Addr / Write_Data  output  1 / NBITS / WORD_LENGTH  register-file write port.
REQ-016 Busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement the FSM states IDLE, ACCESS and RESP.
REQ-018 IDLE with any Req high: pick a winner, latch its Write/Addr/WrData and go to ACCESS on the next edge.
- With no Req high, stay in IDLE.
REQ-019 Arbitration SHALL be round-robin.
- Only one Req high: that requester wins.
- Both Req high: the requester that was not granted last wins.
- The priority pointer resets to A.
REQ-020 ACCESS SHALL last exactly one cycle and drive the following:
- Grant_x = 1.
- Selector = latched Addr.
- For a write: Write_Enable = 1, Write_Addr = Addr, Write_Data = WrData.
REQ-021 Writes to address 0 SHALL be dropped.
- Grant still pulses.
- Write_Enable stays 0.
REQ-022 ACCESS next state SHALL be RESP for a read and IDLE for a write.
REQ-023 For a read, Mux_Output SHALL be captured into RdData at the end of ACCESS.
- RESP drives RdValid_x = 1 for one cycle.
- RESP then returns to IDLE.
REQ-024 Latencies:
- Req high in IDLE at cycle t: Grant at t+1.
- Read: RdValid at t+2.
- Back-to-back reads: one per 3 cycles.
- Back-to-back writes: one per 2 cycles.
REQ-025 Outside ACCESS, Selector, Write_Enable, Write_Addr and Write_Data SHALL be 0.
REQ-026 RdData SHALL hold its last captured value until the next read capture.
REQ-027 Req and its qualifiers SHALL be sampled only in IDLE.
- Changes in other states are ignored.
- A Req dropped before sampling generates no transaction.
REQ-028 A write followed by a read of the same address from the other requester SHALL return the new data, because transactions are serialized.
REQ-029 Grant_A and Grant_B SHALL never both be high; the same holds for RdValid_A and RdValid_B.

Reset
REQ-030 While reset is high, all outputs SHALL be 0.
- State = IDLE.
- Priority pointer = A.
- RdData = 0.
REQ-031 Reset asserted mid-ACCESS or mid-RESP SHALL abort the transaction.
- No further Grant or RdValid is issued.
- A write in progress is suppressed asynchronously.
REQ-032 After reset is released, the first arbitration SHALL occur on the first rising edge with a Req high.

Structure
REQ-033 Package regfile_arb_pkg SHALL hold the following:
- WORD_LENGTH default.
- NBITS default.
- FSM state encoding for IDLE, ACCESS and RESP.
- The requester ID constants REQ_A and REQ_B.
REQ-034 A sub-module rr_picker2 SHALL contain the round-robin choice logic.
- Inputs: two requests and the last-granted bit.
- Output: winner ID.
- The FSM, latches and output logic stay in regfile_access_arbiter.

Verification
REQ-035 Bench setup: connect the mux to a register-file model preloaded with Data_i = i.
REQ-036 Single read: Req_A=1, Write_A=0, Addr_A=3 -> Grant_A at t+1 with Selector=3, RdValid_A at t+2 with RdData=3.
REQ-037 Simultaneous reads after reset:
- Stimulus: A Addr=5, B Addr=16, both held.
- Required: Grant_A first (RdData=5), then Grant_B 3 cycles later (RdData=16).
REQ-038 Write then read:
- Stimulus: A writes 0xDEADBEEF to 25, while B is requesting a read of 25.
- Required: Write_Enable pulse with Write_Addr=25, then B's RdData=0xDEADBEEF.
REQ-039 Write to address 0 with data 7: Grant pulses, Write_Enable stays 0, and a later read of 0 returns 0.
REQ-040 Reset mid-read: assert reset during the ACCESS cycle -> no RdValid, Busy=0, and the next contended request is granted to A.
